pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit; successor to the single-branch PC adder.
//  - Holds the fetch PC and selects the next PC: sequential +4, all six
//    conditional branches, JAL and JALR.
//  - Supports pipeline stall and raises a timed flush window after a redirect.
//  - Sits between the decode/ALU stage and instruction fetch in SEQ and pipelined cores.
// PARAMETERS
//  PC_W         32   width of PC, targets and rs1_val
//  IMM_W        64   width of imm_gen_out
//  IMM_SHIFT    1    left shift applied to imm for branch/JAL targets (not JALR)
//  RESET_PC     0    PC value loaded on reset
//  FLUSH_CYCLES 2    flush pulse length after a taken redirect (>=1)
//  TRAP_VEC     'h100  PC loaded on misaligned target (PC_MISALIGN_TRAP_EN only)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  stall        in   1      hold PC, taken and flush counter
//  branch       in   1      conditional branch instruction present
//  branch_op    in   3      funct3: BEQ 000 BNE 001 BLT 100 BGE 101 BLTU 110 BGEU 111
//  alu_zero     in   1      rs1==rs2
//  alu_lt       in   1      rs1<rs2, signed
//  alu_ltu      in   1      rs1<rs2, unsigned
//  jal          in   1      JAL present
//  jalr         in   1      JALR present
//  imm_gen_out  in   IMM_W  sign-extended immediate
//  rs1_val      in   PC_W   JALR base
//  pc_out       out  PC_W   registered current PC
//  pc_plus4     out  PC_W   pc_out+4, combinational (link value)
//  taken        out  1      registered: last PC update was a redirect
//  flush        out  1      high while FSM in FLUSH
//  misaligned   out  1      registered 1-cycle pulse (macro only; else tied 0)
// BEHAVIOUR
//  - Reset: pc_out=RESET_PC, taken=0, flush=0, misaligned=0, state=RUN, cnt=0.
//    Asserting reset mid-FLUSH aborts the flush immediately.
//  - Next-PC priority per edge: reset > stall > FLUSH-squash > jalr > jal > branch-taken > +4.
//  - stall=1: pc_out, taken, misaligned, state and cnt all hold.
//  - Branch condition: BEQ zero; BNE !zero; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu.
//    Reserved funct3 (010, 011) = not taken.
//  - Targets, all modulo 2^PC_W (wrap, no flag):
//      br/jal = pc_out + (imm_gen_out[PC_W-1:0] << IMM_SHIFT)
//      jalr   = (rs1_val + imm_gen_out[PC_W-1:0]) & ~1
//  - Redirect (jalr|jal|branch-taken) in RUN: pc_out<=target, taken<=1,
//    state<=FLUSH, cnt<=FLUSH_CYCLES-1. Otherwise pc_out<=pc_out+4, taken<=0.
//  - FLUSH: flush=1; branch/jal/jalr ignored (wrong-path squash); PC +4.
//    cnt==0 -> RUN, else cnt--. Latency redirect->flush: 1 edge.
//  - pc_out 0xFFFF_FFFC + 4 wraps to 0.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//    - A redirect target with target[1:0]!=0 (JALR after bit0 clear) loads TRAP_VEC.
//    - misaligned<=1 for one cycle, taken<=1, FLUSH entered as for a normal redirect.
//  Not defined: target used as computed, no check; misaligned tied 0.
// STRUCTURE
//  - pc_unit_pkg: branch_op_e enum (funct3 codes), pc_state_e {RUN, FLUSH},
//    PC_INC=4 constant.
//  - Sub-module pc_branch_cmp: combinational branch_op + flags -> cond.
//  - Top holds target mux, PC register and flush FSM/counter.
// TESTING
//  1 reset=1 mid-run, RESET_PC=0 -> pc_out=0, taken=0, flush=0 same cycle;
//    release -> 0, 4, 8.
//  2 pc=0x40, branch=1, BNE, alu_zero=0, imm=8 -> next pc=0x50, taken=1;
//    flush high 2 cycles; pc 0x54, 0x58.
//  3 pc=0x40, BGE, alu_lt=1 -> pc=0x44, taken=0, flush=0;
//    BLTU, ltu=1, imm=-4 -> pc=0x3C.
//  4 jal=1 and jalr=1 together, rs1=0x201, imm=4 -> pc=0x204 (jalr wins);
//    jal during FLUSH ignored.
//  5 stall=1 for 3 cycles during FLUSH -> pc, flush, cnt frozen;
//    flush lasts 2 unstalled cycles.
//  6 macro on: jal with imm=1 (target pc+2) -> pc=TRAP_VEC, misaligned 1-cycle pulse;
//    macro off -> pc=pc+2.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit: branch funct3
// encodings, flush FSM states, PC increment and a counter-width helper.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pc_state_e;

    localparam int unsigned PC_INC = 4;

    // Bits needed to hold a down-counter starting at n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_branch_cmp.sv
// Combinational branch-condition evaluator: maps funct3 plus the ALU compare
// flags to a single taken condition. Reserved funct3 codes never take.
module pc_branch_cmp
    import pc_unit_pkg::*;
(
    input  logic [2:0] branch_op,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (branch_op)
            BR_BEQ:  cond = alu_zero;
            BR_BNE:  cond = !alu_zero;
            BR_BLT:  cond = alu_lt;
            BR_BGE:  cond = !alu_lt;
            BR_BLTU: cond = alu_ltu;
            BR_BGEU: cond = !alu_ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (+4, branches, JAL, JALR), stall,
// and a timed flush window after redirects. Optional misaligned-target trap
// is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     PC_W         = 32,
    parameter int unsigned     IMM_W        = 64,
    parameter int unsigned     IMM_SHIFT    = 1,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0] TRAP_VEC     = 'h100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic [2:0]        branch_op,
    input  logic              alu_zero,
    input  logic              alu_lt,
    input  logic              alu_ltu,
    input  logic              jal,
    input  logic              jalr,
    input  logic [IMM_W-1:0]  imm_gen_out,
    input  logic [PC_W-1:0]   rs1_val,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   pc_plus4,
    output logic              taken,
    output logic              flush,
    output logic              misaligned
);

    localparam int unsigned CNT_W = cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             taken_q, taken_d;
    pc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PC_W-1:0]  imm_pc;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  jalr_sum;
    logic [PC_W-1:0]  redir_target;
    logic [PC_W-1:0]  redir_pc;
    logic             target_mis;
    logic             br_cond;
    logic             redirect_req;

    // Immediate narrowed (or sign-extended) to PC width; targets wrap mod 2^PC_W.
    generate
        if (IMM_W >= PC_W) begin : g_imm_trunc
            assign imm_pc = imm_gen_out[PC_W-1:0];
            if (IMM_W > PC_W) begin : g_imm_hi
                logic [IMM_W-PC_W-1:0] imm_hi_unused;
                assign imm_hi_unused = imm_gen_out[IMM_W-1:PC_W];
            end
        end else begin : g_imm_sext
            assign imm_pc = {{(PC_W - IMM_W){imm_gen_out[IMM_W-1]}}, imm_gen_out};
        end
    endgenerate

    pc_branch_cmp u_branch_cmp (
        .branch_op (branch_op),
        .alu_zero  (alu_zero),
        .alu_lt    (alu_lt),
        .alu_ltu   (alu_ltu),
        .cond      (br_cond)
    );

    assign pc_plus4     = pc_q + PC_W'(PC_INC);
    assign br_target    = pc_q + (imm_pc << IMM_SHIFT);
    assign jalr_sum     = rs1_val + imm_pc;
    assign redirect_req = jalr | jal | (branch & br_cond);
    assign redir_target = jalr ? {jalr_sum[PC_W-1:1], 1'b0} : br_target;

`ifdef PC_MISALIGN_TRAP_EN
    logic mis_q, mis_d;

    assign target_mis = |redir_target[1:0];
    assign redir_pc   = target_mis ? TRAP_VEC : redir_target;

    // Pulse only on the redirect edge itself; holds while stalled.
    always_comb begin
        mis_d = mis_q;
        if (!stall) begin
            mis_d = (state_q == ST_RUN) && redirect_req && target_mis;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign misaligned = mis_q;
`else
    logic [PC_W-1:0] trap_vec_unused;

    assign trap_vec_unused = TRAP_VEC;
    assign target_mis      = 1'b0;
    assign redir_pc        = redir_target;
    assign misaligned      = 1'b0;
`endif

    // Next-state: stall freezes everything; FLUSH squashes any control transfer.
    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            pc_d    = pc_plus4;
            taken_d = 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (redirect_req) begin
                        pc_d    = redir_pc;
                        taken_d = 1'b1;
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_out = pc_q;
    assign taken  = taken_q;
    assign flush  = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes hand-computed expectations per
// edge, monitor pops and compares one cycle later.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [2:0]  branch_op;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_ltu;
    logic        jal;
    logic        jalr;
    logic [63:0] imm_gen_out;
    logic [31:0] rs1_val;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        flush;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        t;
        logic        f;
        logic        m;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch      (branch),
        .branch_op   (branch_op),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .alu_ltu     (alu_ltu),
        .jal         (jal),
        .jalr        (jalr),
        .imm_gen_out (imm_gen_out),
        .rs1_val     (rs1_val),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .taken       (taken),
        .flush       (flush),
        .misaligned  (misaligned)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic idle();
        stall = 0; branch = 0; branch_op = 3'b000; alu_zero = 0; alu_lt = 0;
        alu_ltu = 0; jal = 0; jalr = 0; imm_gen_out = '0; rs1_val = '0;
    endtask

    // Push the state expected after the coming edge, then move to next negedge.
    task automatic ex(input string n, input logic [31:0] pc, input logic t,
                      input logic f, input logic m = 1'b0);
        exp_t e;
        e.name = n; e.pc = pc; e.t = t; e.f = f; e.m = m;
        exp_q.push_back(e);
        @(negedge clk);
        idle();
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %-10s pc=0x%08h taken=%0b flush=%0b mis=%0b",
                         e.name, pc_out, taken, flush, misaligned);
                chk({e.name, ".pc"},     pc_out,             e.pc);
                chk({e.name, ".pc4"},    pc_plus4,           e.pc + 32'd4);
                chk({e.name, ".taken"},  32'(taken),         32'(e.t));
                chk({e.name, ".flush"},  32'(flush),         32'(e.f));
                chk({e.name, ".mis"},    32'(misaligned),    32'(e.m));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Driver
    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // 1: run, mid-run async reset, release
        for (int i = 1; i <= 4; i++) ex("run", 32'(4 * i), 0, 0);
        reset = 1'b1;
        #1;
        chk("rst_async.pc", pc_out, 32'h0);
        chk("rst_async.taken", 32'(taken), 32'h0);
        chk("rst_async.flush", 32'(flush), 32'h0);
        ex("rst_hold", 32'h0, 0, 0);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) ex("run", 32'(4 * i), 0, 0);
        // 2: BNE taken from 0x40
        branch = 1; branch_op = 3'b001; alu_zero = 0; imm_gen_out = 64'd8;
        ex("bne_tk", 32'h50, 1, 1);
        ex("flush1", 32'h54, 0, 1);
        ex("flush2", 32'h58, 0, 0);
        // back to 0x40 via JAL with negative offset
        jal = 1; imm_gen_out = -64'd16;
        ex("jal_back", 32'h38, 1, 1);
        ex("flush1", 32'h3C, 0, 1);
        ex("flush2", 32'h40, 0, 0);
        // 3: BGE not taken, BLTU taken backward
        branch = 1; branch_op = 3'b101; alu_lt = 1; imm_gen_out = 64'd8;
        ex("bge_nt", 32'h44, 0, 0);
        branch = 1; branch_op = 3'b110; alu_ltu = 1; imm_gen_out = -64'd4;
        ex("bltu_tk", 32'h3C, 1, 1);
        ex("flush1", 32'h40, 0, 1);
        ex("flush2", 32'h44, 0, 0);
        branch = 1; branch_op = 3'b010; alu_zero = 1; alu_lt = 1; alu_ltu = 1; imm_gen_out = 64'd8;
        ex("rsvd_nt", 32'h48, 0, 0);
        branch = 1; branch_op = 3'b000; alu_zero = 0; imm_gen_out = 64'd8;
        ex("beq_nt", 32'h4C, 0, 0);
        branch = 1; branch_op = 3'b100; alu_lt = 1; imm_gen_out = 64'd2;
        ex("blt_tk", 32'h50, 1, 1);
        jal = 1; imm_gen_out = 64'h100;
        ex("jal_squash", 32'h54, 0, 1);
        ex("flush2", 32'h58, 0, 0);
        // 4: JAL+JALR together, JALR wins; JAL in FLUSH ignored
        jal = 1; jalr = 1; rs1_val = 32'h201; imm_gen_out = 64'd4;
        ex("jalr_win", 32'h204, 1, 1);
        jal = 1; imm_gen_out = 64'h40;
        ex("jal_squash", 32'h208, 0, 1);
        ex("flush2", 32'h20C, 0, 0);
        // 5: stall during FLUSH
        branch = 1; branch_op = 3'b111; alu_ltu = 0; imm_gen_out = 64'h10;
        ex("bgeu_tk", 32'h22C, 1, 1);
        for (int i = 0; i < 3; i++) begin
            stall = 1;
            ex("stall_fl", 32'h22C, 1, 1);
        end
        ex("flush1", 32'h230, 0, 1);
        ex("flush2", 32'h234, 0, 0);
        stall = 1; jal = 1; imm_gen_out = 64'h10;
        ex("stall_run", 32'h234, 0, 0);
        // 6: misaligned JAL target
        jal = 1; imm_gen_out = 64'd1;
`ifdef PC_MISALIGN_TRAP_EN
        ex("jal_mis", 32'h100, 1, 1, 1);
        ex("flush1", 32'h104, 0, 1);
        ex("flush2", 32'h108, 0, 0);
`else
        ex("jal_mis", 32'h236, 1, 1);
        ex("flush1", 32'h23A, 0, 1);
        ex("flush2", 32'h23E, 0, 0);
`endif
        // wrap at top of address space
        jalr = 1; rs1_val = 32'hFFFF_FFF0; imm_gen_out = 64'hC;
        ex("jalr_top", 32'hFFFF_FFFC, 1, 1);
        ex("wrap", 32'h0, 0, 1);
        ex("flush2", 32'h4, 0, 0);
        branch = 1; branch_op = 3'b101; alu_lt = 0; imm_gen_out = 64'd4;
        ex("bge_tk", 32'hC, 1, 1);
        // reset mid-FLUSH aborts the flush immediately
        reset = 1'b1;
        #1;
        chk("rst_fl.pc", pc_out, 32'h0);
        chk("rst_fl.taken", 32'(taken), 32'h0);
        chk("rst_fl.flush", 32'(flush), 32'h0);
        ex("rst_hold", 32'h0, 0, 0);
        reset = 1'b0;
        ex("post_rst", 32'h4, 0, 0);
        ex("post_rst", 32'h8, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
